// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_e     : arbiter FSM states (idle, one-cycle start, wait for done)
//   DefaultDataW    : default byte width carried to the transmitter
//   DefaultTimeout  : default idle cycles a locked owner may hold the grant
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StWait = 2'd2
   } arb_state_e;

   localparam int unsigned DefaultDataW   = 8;
   localparam int unsigned DefaultTimeout = 1023;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Lock timeout counter for the UART transmit arbiter.
// Counts enabled cycles and saturates at TIMEOUT (never wraps).
// Ports:
//   clk     : clock
//   reset   : asynchronous active-low reset
//   clear   : synchronous clear, wins over enable
//   enable  : count this cycle
//   expired : counter has reached TIMEOUT
module arb_timeout_cnt
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = DefaultTimeout
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

   logic [CntW-1:0] cnt_q;

   assign expired = (cnt_q == Limit);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && !expired) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a UART transmitter.
// Grants one byte source at a time (round-robin when both are valid), locks the
// owner until the byte flagged last has been sent, and drops a lock that sits
// idle for TIMEOUT cycles.
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset
//   reqN_valid/data/last            : byte offered by requester N
//   reqN_ready                      : byte from requester N accepted this cycle
//   tx_start, tx_data               : start pulse and held byte to the transmitter
//   tx_done                         : end-of-stop-bit pulse from the transmitter
//   grant                           : one-hot current owner, 00 when free
//   lock_err                        : one-cycle pulse when a locked owner times out
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W  = DefaultDataW,
   parameter int unsigned TIMEOUT = DefaultTimeout
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req0_last,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              req1_last,
   output logic              req1_ready,
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_data,
   input  logic              tx_done,
   output logic [1:0]        grant,
   output logic              lock_err
);

   arb_state_e        state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic              lock_q, lock_d;
   logic              rr_q, rr_d;      // 0: favour req0, 1: favour req1
   logic              last_q, last_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;

   logic sel0, sel1;
   logic cnt_clear, cnt_enable, cnt_expired;

   assign cnt_enable = (state_q == StIdle) && lock_q;

   arb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk     (clk),
      .reset   (reset),
      .clear   (cnt_clear),
      .enable  (cnt_enable),
      .expired (cnt_expired)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      lock_d    = lock_q;
      rr_d      = rr_q;
      last_d    = last_q;
      tx_data_d = tx_data_q;
      sel0      = 1'b0;
      sel1      = 1'b0;
      cnt_clear = 1'b0;
      lock_err  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (lock_q) begin
               // Only the locked owner may continue its packet.
               sel0 = grant_q[0] & req0_valid;
               sel1 = grant_q[1] & req1_valid;
               // A transfer in the expiry cycle takes precedence over the timeout.
               if (!(sel0 || sel1) && cnt_expired) begin
                  lock_err  = 1'b1;
                  lock_d    = 1'b0;
                  grant_d   = 2'b00;
                  rr_d      = grant_q[0];
                  cnt_clear = 1'b1;
               end
            end else if (req0_valid && req1_valid) begin
               sel0 = ~rr_q;
               sel1 = rr_q;
            end else begin
               sel0 = req0_valid;
               sel1 = req1_valid;
            end

            if (sel0 || sel1) begin
               tx_data_d = sel0 ? req0_data : req1_data;
               last_d    = sel0 ? req0_last : req1_last;
               grant_d   = {sel1, sel0};
               lock_d    = 1'b1;
               cnt_clear = 1'b1;
               state_d   = StSend;
            end
         end

         StSend: begin
            state_d = StWait;
         end

         StWait: begin
            if (tx_done) begin
               state_d = StIdle;
               if (last_q) begin
                  lock_d    = 1'b0;
                  grant_d   = 2'b00;
                  rr_d      = grant_q[0];
                  cnt_clear = 1'b1;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         grant_q   <= 2'b00;
         lock_q    <= 1'b0;
         rr_q      <= 1'b0;
         last_q    <= 1'b0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         lock_q    <= lock_d;
         rr_q      <= rr_d;
         last_q    <= last_d;
         tx_data_q <= tx_data_d;
      end
   end

   // Ready is combinational from valid, so hold it low while reset is asserted.
   assign req0_ready = sel0 & reset;
   assign req1_ready = sel1 & reset;
   assign tx_start   = (state_q == StSend);
   assign tx_data    = tx_data_q;
   assign grant      = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, byte width carried to the transmitter.
REQ-002 Parameter TIMEOUT, default 1023, maximum idle cycles a locked owner may hold the grant between bytes.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester has a byte on its data port.
REQ-006 req0_data / req1_data  input  DATA_W  byte offered by the requester.
REQ-007 req0_last / req1_last  input  1  offered byte ends the requester's packet.
REQ-008 req0_ready / req1_ready  output  1  byte accepted this cycle; transfer occurs when valid and ready are both high at the rising edge.
REQ-009 tx_start  output  1  one-cycle pulse that starts the transmitter on tx_data.
REQ-010 tx_data  output  DATA_W  byte to the transmitter, held stable from tx_start until tx_done.
REQ-011 tx_done  input  1  one-cycle pulse from the transmitter at the end of the stop bit.
REQ-012 grant  output  2  one-hot current owner; 2'b00 when nobody holds the grant.
REQ-013 lock_err  output  1  one-cycle pulse when a locked owner times out.

Function
REQ-014 FSM states: IDLE, SEND, WAIT.
REQ-015 IDLE, unlocked: if exactly one valid, grant that requester; if both valid, grant the requester not served last (round-robin pointer); ready of the granted requester goes high combinationally in the same cycle.
REQ-016 IDLE, locked: only the locked owner is considered; the other requester's valid is ignored and its ready is 0.
REQ-017 On transfer: capture data into tx_data and last into an internal flag, set grant/lock to the owner, go to SEND.
REQ-018 SEND lasts exactly one cycle: tx_start=1, then go to WAIT; latency from accepting transfer edge to tx_start is 1 cycle.
REQ-019 WAIT: hold tx_data; on tx_done go to IDLE; if the captured last=1, clear the lock and the grant, and point round-robin at the other requester; otherwise keep the lock.
REQ-020 tx_done in IDLE or SEND is ignored.
REQ-021 All ready outputs are 0 in SEND and WAIT; at most one ready is high in any cycle.
REQ-022 The timeout counter counts cycles spent in IDLE while locked; it is cleared on every transfer and on unlock.
REQ-023 When the counter reaches TIMEOUT without a transfer: pulse lock_err for one cycle, clear the lock and the grant, and point round-robin at the other requester.
REQ-024 If the owner presents valid in the same cycle the counter reaches TIMEOUT, the transfer wins and lock_err stays 0.
REQ-025 Counter width is $clog2(TIMEOUT+1); it never wraps.

Reset
REQ-026 While reset=0: state IDLE, grant=2'b00, lock cleared, round-robin favours req0, counter=0, tx_start=0, tx_data=0, lock_err=0, all ready=0.
REQ-027 Reset asserted mid-byte aborts the transfer with no tx_start issued afterwards; the first grant after release follows the REQ-015 rules.

Structure
REQ-028 The shared package holds the FSM state enum (IDLE, SEND, WAIT) and the default DATA_W/TIMEOUT constants.
REQ-029 The timeout counter is a sub-module, arb_timeout_cnt (inputs clear and enable; output expired).
REQ-030 The block sits between the byte sources and the Transmitter and replaces the direct FIFO-to-transmitter connection.

Verification
REQ-031 Single byte: req0 sends 0xA5 with last=1, and tx_done arrives 10 cycles after tx_start -> req0_ready for 1 cycle, tx_start 1 cycle later with tx_data=0xA5, grant=00 after tx_done.
REQ-032 Contention: both valid in IDLE after reset -> req0 granted first; after its last byte completes, req1 is granted; alternation continues over 4 packets.
REQ-033 Lock: req0 packet 0x01,0x02,0x03 (last on 0x03) with req1 continuously valid -> the transmitter sees 01,02,03 before any req1 byte; req1_ready stays 0 throughout.
REQ-034 Timeout: TIMEOUT=8, req0 sends 0x11 with last=0 and then drops valid -> lock_err pulses 8 cycles after returning to IDLE, then the pending req1 is granted.
REQ-035 Reset mid-WAIT: reset asserted during WAIT -> all outputs reach their reset values immediately, and a stray tx_done after release produces no tx_start.
REQ-036 Spurious tx_done in IDLE or SEND -> no state change and no ready pulse.
